// File: rtl/regfile_writeback.sv
// regfile_writeback: arbitrates the register file write port between the
// single-cycle ALU path and a FIFO of long-latency results, and keeps a
// pending-write scoreboard that decode uses for RAW hazard detection.
module regfile_writeback #(
    parameter int XLEN         = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_stall,
    input  logic            ext_valid,
    output logic            ext_ready,
    input  logic [4:0]      ext_rd,
    input  logic [XLEN-1:0] ext_data,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    input  logic [4:0]      query_rs1,
    input  logic [4:0]      query_rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            wen,
    output logic [4:0]      waddr,
    output logic [XLEN-1:0] wdata
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

    // Saturating increment of the starvation counter.
    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
        return (v == LIMIT_C) ? v : v + SW'(1);
    endfunction

    logic [4:0]      rd_mem_q   [FIFO_DEPTH];
    logic [XLEN-1:0] data_mem_q [FIFO_DEPTH];

    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count;
    logic [SW-1:0]   starve_q, starve_d;
    logic [31:0]     pend_q, pend_d;
    logic            wen_q, wen_d;
    logic [4:0]      waddr_q, waddr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;

    logic            full, empty, push, pop;
    logic            alu_cand, sel_fifo;
    logic [4:0]      head_rd;
    logic [XLEN-1:0] head_data;

    assign count     = wr_ptr_q - rd_ptr_q;
    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign ext_ready = !full;
    assign push      = ext_valid && !full;
    assign head_rd   = rd_mem_q[rd_ptr_q[AW-1:0]];
    assign head_data = data_mem_q[rd_ptr_q[AW-1:0]];

    // ALU has priority unless the FIFO head has waited STARVE_LIMIT cycles.
    // An ALU write to x0 is never a candidate, so it is simply absorbed.
    assign alu_cand  = alu_valid && (alu_rd != 5'd0);
    assign sel_fifo  = !empty && (!alu_cand || (starve_q == LIMIT_C));
    assign pop       = sel_fifo;
    assign alu_stall = alu_cand && sel_fifo;

    assign rs1_busy  = pend_q[query_rs1];
    assign rs2_busy  = pend_q[query_rs2];
    assign wen       = wen_q;
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;

    // Next-state: pointers, starvation counter, write port, scoreboard.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

        if (empty || pop) starve_d = '0;
        else              starve_d = sat_inc(starve_q);

        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (sel_fifo) begin
            if (head_rd != 5'd0) begin
                wen_d   = 1'b1;
                waddr_d = head_rd;
                wdata_d = head_data;
            end
        end else if (alu_cand) begin
            wen_d   = 1'b1;
            waddr_d = alu_rd;
            wdata_d = alu_data;
        end

        // Clear first so a same-cycle issue to the same register wins.
        pend_d = pend_q;
        if (pop && (head_rd != 5'd0))
            pend_d[head_rd] = 1'b0;
        if (issue_valid && (issue_rd != 5'd0))
            pend_d[issue_rd] = 1'b1;
        pend_d[0] = 1'b0;
    end

    // Control and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            starve_q <= '0;
            pend_q   <= '0;
            wen_q    <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            starve_q <= starve_d;
            pend_q   <= pend_d;
            wen_q    <= wen_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem_q[wr_ptr_q[AW-1:0]]   <= ext_rd;
            data_mem_q[wr_ptr_q[AW-1:0]] <= ext_data;
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Testbench for regfile_writeback: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_regfile_writeback;

    localparam int XLEN         = 32;
    localparam int FIFO_DEPTH   = 4;
    localparam int STARVE_LIMIT = 3;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_stall;
    logic            ext_valid;
    logic            ext_ready;
    logic [4:0]      ext_rd;
    logic [XLEN-1:0] ext_data;
    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic [4:0]      query_rs1, query_rs2;
    logic            rs1_busy, rs2_busy;
    logic            wen;
    logic [4:0]      waddr;
    logic [XLEN-1:0] wdata;

    regfile_writeback #(
        .XLEN(XLEN), .FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
        .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_rd(ext_rd), .ext_data(ext_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .query_rs1(query_rs1), .query_rs2(query_rs2),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .wen(wen), .waddr(waddr), .wdata(wdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, scoreboard as a bit array.
    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ent_t;

    ent_t            q_m[$];
    bit              pend_m[32];
    int              starve_m;
    logic            exp_wen;
    logic [4:0]      exp_waddr;
    logic [XLEN-1:0] exp_wdata;
    bit              last_stall;
    bit              last_ready;

    task automatic model_reset();
        q_m.delete();
        for (int i = 0; i < 32; i++) pend_m[i] = 0;
        starve_m   = 0;
        exp_wen    = 1'b0;
        exp_waddr  = '0;
        exp_wdata  = '0;
        last_stall = 0;
        last_ready = 1;
    endtask

    task automatic set_idle();
        alu_valid   = 1'b0;
        alu_rd      = '0;
        alu_data    = '0;
        ext_valid   = 1'b0;
        ext_rd      = '0;
        ext_data    = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
    endtask

    // One cycle: called just after a falling edge with inputs applied.
    task automatic step();
        bit   alu_c, fifo_c, fifo_wins, ready_pre;
        ent_t e;
        #1;
        alu_c     = alu_valid && (alu_rd != 5'd0);
        fifo_c    = (q_m.size() != 0);
        fifo_wins = fifo_c && (!alu_c || starve_m == STARVE_LIMIT);
        ready_pre = (q_m.size() < FIFO_DEPTH);
        chk("alu_stall", alu_stall, alu_c && fifo_wins);
        chk("ext_ready", ext_ready, ready_pre);
        chk("rs1_busy", rs1_busy, pend_m[query_rs1]);
        chk("rs2_busy", rs2_busy, pend_m[query_rs2]);
        last_stall = alu_c && fifo_wins;
        last_ready = ready_pre;
        @(posedge clk);
        exp_wen = 1'b0;
        if (fifo_wins) begin
            e = q_m.pop_front();
            if (e.rd != 5'd0) begin
                exp_wen   = 1'b1;
                exp_waddr = e.rd;
                exp_wdata = e.data;
                pend_m[e.rd] = 0;
            end
        end else if (alu_c) begin
            exp_wen   = 1'b1;
            exp_waddr = alu_rd;
            exp_wdata = alu_data;
        end
        if (ext_valid && ready_pre) begin
            e.rd   = ext_rd;
            e.data = ext_data;
            q_m.push_back(e);
        end
        if (fifo_wins || !fifo_c) starve_m = 0;
        else if (starve_m < STARVE_LIMIT) starve_m++;
        if (issue_valid && issue_rd != 5'd0) pend_m[issue_rd] = 1;
        #1;
        chk("wen", wen, exp_wen);
        chk("waddr", waddr, exp_waddr);
        chk("wdata", wdata, exp_wdata);
        @(negedge clk);
    endtask

    // Pick an ALU destination that is not pending (decode's contract).
    function automatic logic [4:0] free_rd();
        logic [4:0] r;
        for (int t = 0; t < 8; t++) begin
            r = 5'($urandom_range(1, 31));
            if (!pend_m[r]) return r;
        end
        return 5'd0;
    endfunction

    int nstall;
    bit saw_full;
    int ext_idx;

    initial begin
        model_reset();
        set_idle();
        query_rs1 = '0;
        query_rs2 = '0;
        reset_n   = 1'b0;
        #1;
        chk("rst_wen", wen, 1'b0);
        chk("rst_waddr", waddr, 5'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_ext_ready", ext_ready, 1'b1);
        chk("rst_alu_stall", alu_stall, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // ALU write, then ALU write to x0.
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hDEADBEEF;
        step();
        chk("alu_waddr", waddr, 5'd3);
        chk("alu_wdata", wdata, 32'hDEADBEEF);
        alu_rd = 5'd0; alu_data = 32'h0BADF00D;
        step();
        set_idle();

        // Long-latency path with scoreboard.
        issue_valid = 1'b1; issue_rd = 5'd7; query_rs2 = 5'd7;
        step();
        set_idle();
        step();
        ext_valid = 1'b1; ext_rd = 5'd7; ext_data = 32'h12345678;
        step();
        set_idle();
        step();
        chk("ll_wen", wen, 1'b1);
        chk("ll_wdata", wdata, 32'h12345678);
        #1;
        chk("ll_busy_drop", rs2_busy, 1'b0);
        step();

        // Starvation: one FIFO entry, ALU valid every cycle.
        ext_valid = 1'b1; ext_rd = 5'd12; ext_data = 32'hCAFE0012;
        step();
        ext_valid = 1'b0;
        nstall = 0;
        last_stall = 0;
        for (int i = 0; i < 7; i++) begin
            alu_valid = 1'b1;
            if (!last_stall) begin
                alu_rd   = free_rd();
                alu_data = $urandom;
            end
            step();
            if (last_stall) nstall++;
        end
        chk("starve_stalls", nstall, 1);
        set_idle();
        step();

        // Full FIFO with ALU saturating the port.
        saw_full = 0;
        ext_idx  = 0;
        last_stall = 0;
        last_ready = 1;
        for (int i = 0; i < 12; i++) begin
            alu_valid = 1'b1;
            if (!last_stall) begin
                alu_rd   = free_rd();
                alu_data = $urandom;
            end
            ext_valid = (ext_idx < 5);
            ext_rd    = 5'(20 + ext_idx);
            ext_data  = 32'hE0000000 + ext_idx;
            step();
            if (!last_ready) saw_full = 1;
            if (ext_valid && last_ready) ext_idx++;
        end
        chk("full_seen", saw_full, 1'b1);
        chk("full_all_pushed", ext_idx, 5);
        set_idle();
        repeat (6) step();

        // Same-cycle set and clear of one pend bit: set wins.
        ext_valid = 1'b1; ext_rd = 5'd9; ext_data = 32'h00000009;
        step();
        set_idle();
        issue_valid = 1'b1; issue_rd = 5'd9; query_rs1 = 5'd9;
        step();
        set_idle();
        #1;
        chk("set_wins", rs1_busy, 1'b1);
        step();
        ext_valid = 1'b1; ext_rd = 5'd9; ext_data = 32'h00000099;
        step();
        set_idle();
        repeat (2) step();

        // Randomized traffic.
        last_stall = 0;
        for (int i = 0; i < 500; i++) begin
            if (!last_stall) begin
                alu_valid = ($urandom_range(0, 3) != 0);
                alu_rd    = ($urandom_range(0, 9) == 0) ? 5'd0 : free_rd();
                alu_data  = $urandom;
            end
            ext_valid   = ($urandom_range(0, 2) == 0);
            ext_rd      = 5'($urandom_range(0, 31));
            ext_data    = $urandom;
            issue_valid = ($urandom_range(0, 4) == 0);
            issue_rd    = 5'($urandom_range(0, 31));
            query_rs1   = 5'($urandom_range(0, 31));
            query_rs2   = 5'($urandom_range(0, 31));
            step();
        end
        set_idle();
        repeat (6) step();

        // Asynchronous reset mid-cycle with buffered entries and pend[5].
        issue_valid = 1'b1; issue_rd = 5'd5;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11111111;
        ext_valid = 1'b1; ext_rd = 5'd5; ext_data = 32'h55555555;
        step();
        issue_valid = 1'b0;
        alu_rd = 5'd2; alu_data = 32'h22222222;
        ext_rd = 5'd6; ext_data = 32'h66666666;
        query_rs1 = 5'd5;
        step();
        chk("pre_rst_depth", q_m.size(), 2);
        set_idle();
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_wen", wen, 1'b0);
        chk("mid_rst_ext_ready", ext_ready, 1'b1);
        chk("mid_rst_rs1_busy", rs1_busy, 1'b0);
        chk("mid_rst_wdata", wdata, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-back arbiter that drives the single write port of the 32-entry integer register file from two producers: the single-cycle ALU path and a long-latency path (load/store unit, multiply/divide) buffered through a small FIFO. It owns a pending-write scoreboard so decode can detect RAW hazards against outstanding long-latency results. It sits between the execute/memory stages and the register file. Its outputs are registered on the rising edge, so the register file's falling-edge write lands in the same cycle.

## Interface
- XLEN, 32, data width
- FIFO_DEPTH, 4, long-latency result buffer entries (power of two, ≥2)
- STARVE_LIMIT, 3, consecutive denied cycles before the FIFO head is forced ahead of the ALU

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU result present this cycle
- alu_rd  in  5  ALU destination register
- alu_data  in  XLEN  ALU result
- alu_stall  out  1  ALU result not taken; producer holds alu_valid/rd/data
- ext_valid  in  1  long-latency result offered
- ext_ready  out  1  FIFO can accept (= not full)
- ext_rd  in  5  long-latency destination
- ext_data  in  XLEN  long-latency result
- issue_valid  in  1  long-latency instruction issued this cycle
- issue_rd  in  5  its destination
- query_rs1, query_rs2  in  5 each  decode source registers
- rs1_busy, rs2_busy  out  1 each  source has an outstanding long-latency write
- wen  out  1  register file write enable (registered)
- waddr  out  5  register file write address (registered)
- wdata  out  XLEN  register file write data (registered)

## Operation
- FIFO push on ext_valid && ext_ready; ext_ready = !full (no same-cycle pass-through when full).
- Each cycle exactly one candidate is selected:
  - ALU candidate: alu_valid && alu_rd != 0.
  - FIFO candidate: FIFO not empty.
- Default priority is ALU over FIFO.
- Starvation counter (width clog2(STARVE_LIMIT+1)):
  - Increments each cycle the FIFO is non-empty and not popped.
  - Clears on any pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- When the counter equals STARVE_LIMIT, the FIFO wins. alu_stall = ALU candidate && FIFO selected (combinational).
- ALU writes to x0: accepted (alu_stall = 0) and discarded; wen stays 0.
- FIFO entries with rd = 0: popped as normal with wen = 0; this still counts as a pop.
- Registered outputs on each rising edge:
  - Selected write with rd != 0: wen = 1, waddr = rd, wdata = data.
  - Otherwise: wen = 0; waddr/wdata hold their previous values.
- Scoreboard: a 32-bit pending mask.
  - Set bit issue_rd when issue_valid && issue_rd != 0.
  - Clear bit rd when a FIFO entry with that rd is popped.
  - Same bit set and cleared in the same cycle: set wins.
  - Bit 0 is always 0.
- rs1_busy = pend[query_rs1]; rs2_busy = pend[query_rs2]. Both are combinational from registered state.
- Producer contract: the ALU path never targets a register whose pend bit is set. Decode enforces this; the block does not check it.

## Timing
- Reset (reset_n low, asynchronous):
  - Outputs: wen = 0, waddr = 0, wdata = 0, alu_stall = 0, rs1_busy = rs2_busy = 0.
  - State: FIFO empty, pend = 0, starvation counter = 0.
  - ext_ready = 1 while in reset.
- Reset asserted mid-operation drops all buffered results and pending bits; nothing is written after deassertion.
- Latency, ALU result: accepted in cycle N, wen/waddr/wdata valid from the rising edge ending cycle N. The register file writes at the falling edge within cycle N+1.
- Latency, long-latency result: pushed in cycle N, earliest pop in N+1, wen in N+2.
- The pend bit clears at the same rising edge that asserts wen for that entry. Register file data is valid at the following falling edge; decode reading in the second half of that cycle sees the new value.
- FIFO full and push attempted: ext_ready = 0 and no push. A pop in the same cycle frees a slot only from the next cycle.
- Pointers wrap modulo FIFO_DEPTH. A full/empty distinction uses an extra pointer bit or a count.

## Test plan
- Reset: drive reset_n low asynchronously mid-cycle with 2 FIFO entries and pend[5] = 1 → immediately wen = 0, ext_ready = 1, rs1_busy = 0 for query_rs1 = 5; no write after release.
- ALU only: alu_valid with rd = 3, data = 0xDEADBEEF → next edge: wen = 1, waddr = 3, wdata = 0xDEADBEEF; rd = 0 gives wen = 0 and alu_stall = 0.
- Long-latency path: issue rd = 7 → rs2_busy = 1 for query_rs2 = 7. Push rd = 7, data = 0x12345678 with ALU idle → wen two cycles later; rs2_busy drops at the same edge.
- Starvation: fill FIFO with 1 entry, hold alu_valid every cycle → STARVE_LIMIT = 3 ALU writes, then alu_stall = 1 for one cycle while the FIFO entry writes. The held ALU result follows the next cycle.
- Full FIFO: push 4 entries with ALU saturating → ext_ready = 0. A 5th ext_valid is not accepted until a pop; all 4 entries are written in push order.
- Same-cycle set/clear: issue_valid rd = 9 in the cycle a FIFO entry with rd = 9 pops → pend[9] remains 1.
